// File: rtl/riscv_pkg.sv
// Shared RV32I front-end definitions: data widths, reset vector, fetch-state
// encoding and the PC alignment helper.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Occupancy counters; buffer depths never exceed 8.
  localparam int CNT_W = 4;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count and single-cycle flush.
// Serves as the fetch output buffer ({pc, instr}) and as the request tag queue.
// Push and pop may coincide at any occupancy, including when full.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // Explicit wrap so the tag queue may use a non-power-of-two depth.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
    !(push_i && !do_push));

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: owns the PC, issues word-aligned imem requests under
// a credit limit that reserves a buffer slot for every in-flight response, and
// hands {instr, pc, pc+4} to the decoder. Redirects flush buffered words and
// arm a down-counter that discards the responses still in flight.
//
//   state | meaning
//   FETCH | no stale responses pending (drop_cnt == 0)
//   FLUSH | stale responses pending; requests at the new PC may still issue
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH      = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pc_plus4
);

  localparam int CW1 = CNT_W + 1;
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CW1-1:0]   DEPTH_C   = CW1'(FIFO_DEPTH);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  fetch_state_e      state_q, state_d;

  logic              req_fire, resp_keep, dec_fire;
  logic [CW1-1:0]    credit_use;
  logic [CNT_W-1:0]  fifo_cnt, tag_cnt;
  logic              fifo_empty, tag_empty;
  logic [XLEN-1:0]   tag_pc;
  logic [2*XLEN-1:0] fifo_head;

  // Credit is computed from registered state only, never from redirect_valid.
  assign credit_use     = {1'b0, outst_q} + {1'b0, fifo_cnt};
  assign imem_req_valid = !rst && (outst_q < MAX_OUT_C) && (credit_use < DEPTH_C);
  assign imem_req_addr  = pc_q;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign resp_keep = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign dec_fire  = dec_valid && dec_ready;
  assign outst_d   = outst_q + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);

  // Next PC, stale-response counter and fetch state; redirect has priority.
  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    state_d    = state_q;
    if (redirect_valid) begin
      pc_d       = align_pc(redirect_pc);
      drop_cnt_d = outst_d;
      state_d    = (outst_d != '0) ? FLUSH : FETCH;
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(INSTR_BYTES);
      if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      if (drop_cnt_d == '0) state_d = FETCH;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      outst_q    <= '0;
      drop_cnt_q <= '0;
      state_q    <= FETCH;
    end else begin
      pc_q       <= pc_d;
      outst_q    <= outst_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
    end
  end

  // PC of each live request; a request accepted in a redirect cycle is stale.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (req_fire && !redirect_valid),
    .push_data_i (pc_q),
    .pop_i       (resp_keep),
    .head_o      (tag_pc),
    .count_o     (tag_cnt),
    .empty_o     (tag_empty)
  );

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_out_q (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (resp_keep),
    .push_data_i ({tag_pc, imem_resp_data}),
    .pop_i       (dec_fire),
    .head_o      (fifo_head),
    .count_o     (fifo_cnt),
    .empty_o     (fifo_empty)
  );

  assign dec_valid    = !rst && !fifo_empty;
  assign dec_instr    = fifo_head[XLEN-1:0];
  assign dec_pc       = fifo_head[2*XLEN-1:XLEN];
  assign dec_pc_plus4 = dec_pc + XLEN'(INSTR_BYTES);

  a_outst_max:  assert property (@(posedge clk) disable iff (rst) outst_q <= MAX_OUT_C);
  a_addr_align: assert property (@(posedge clk) disable iff (rst) imem_req_addr[1:0] == 2'b00);
  a_tag_bound:  assert property (@(posedge clk) disable iff (rst) tag_cnt <= outst_q);
  a_tag_avail:  assert property (@(posedge clk) disable iff (rst) resp_keep |-> !tag_empty);
  a_state_cnt:  assert property (@(posedge clk) disable iff (rst)
    (state_q == FLUSH) == (drop_cnt_q != '0));

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with one-cycle minimum latency,
// an expected-delivery queue filled on every accepted request and trimmed on
// redirect/reset, and a monitor that checks every decoder transfer.
module tb_instr_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [31:0] dec_instr, dec_pc, dec_pc_plus4;

  instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .dec_pc_plus4    (dec_pc_plus4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // memory model state
  typedef struct { logic [31:0] addr; int cyc; } mreq_t;
  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = 32'h0;
  logic        mem_ready_en = 1'b1;
  logic        mem_hold = 1'b0;
  int          cyc = 0;

  // Memory: answers in order, at least one cycle after acceptance.
  always @(negedge clk) begin
    #1;
    cyc++;
    imem_resp_valid = 1'b0;
    if (rst) begin
      mq.delete();
      imem_req_ready = 1'b0;
      exp_addr = 32'h0;
    end else begin
      if (!mem_hold && mq.size() > 0 && mq[0].cyc < cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end
      imem_req_ready = mem_ready_en;
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_addr);
        mq.push_back('{addr: imem_req_addr, cyc: cyc});
        exp_q.push_back(imem_req_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (redirect_valid) exp_addr = redirect_pc & ~32'd3;
    end
  end

  // monitor state
  logic        held_v = 1'b0;
  logic [31:0] held_pc, held_instr;
  logic [31:0] post_pc[2];
  logic [31:0] post_p4[2];
  int          post_cnt = 0;

  function automatic void clear_post();
    post_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      post_pc[i] = 32'hDEAD_BEEF;
      post_p4[i] = 32'hDEAD_BEEF;
    end
  endfunction

  // Monitor: checks decoder transfers against the expected queue.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
      clear_post();
    end else begin
      if (held_v) begin
        check("hold_valid", {31'b0, dec_valid}, 32'd1);
        check("hold_pc", dec_pc, held_pc);
        check("hold_instr", dec_instr, held_instr);
      end
      held_v     = dec_valid && !dec_ready && !redirect_valid;
      held_pc    = dec_pc;
      held_instr = dec_instr;
      if (dec_valid && dec_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dec actual_pc=%h expected=none", dec_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("dec_pc", dec_pc, e);
          check("dec_instr", dec_instr, mem_word(e));
          check("dec_pc_plus4", dec_pc_plus4, e + 32'd4);
        end
        if (post_cnt < 2) begin
          post_pc[post_cnt] = dec_pc;
          post_p4[post_cnt] = dec_pc_plus4;
          post_cnt++;
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        clear_post();
      end
    end
  end

  task automatic redirect_to(input logic [31:0] target);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    // reset and first request
    repeat (3) @(negedge clk);
    #3;
    check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);

    // streaming
    repeat (20) @(negedge clk);
    check("stream_pc0", post_pc[0], 32'h0);
    check("stream_p4_0", post_p4[0], 32'h4);
    check("stream_pc1", post_pc[1], 32'h4);

    // decoder stall: buffer fills, requests stop, head holds
    @(negedge clk);
    dec_ready = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("stall_dec_valid", {31'b0, dec_valid}, 32'd1);
    @(negedge clk);
    dec_ready = 1'b1;
    repeat (10) @(negedge clk);

    // two requests outstanding, then redirect (low bits forced to 00)
    mem_hold = 1'b1;
    repeat (8) @(negedge clk);
    #3;
    check("hold_out_full", {31'b0, imem_req_valid}, 32'd0);
    check("hold_drained", {31'b0, dec_valid}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    #3;
    check("flush_state", 32'(dut.state_q), 32'(FLUSH));
    check("flush_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    check("flush_fifo_empty", {31'b0, dec_valid}, 32'd0);
    repeat (10) @(negedge clk);
    check("redir_pc", post_pc[0], 32'h100);
    check("redir_p4", post_p4[0], 32'h104);
    check("redir_state_back", 32'(dut.state_q), 32'(FETCH));

    // redirect coinciding with response + handshake, then a second redirect
    mem_ready_en = 1'b0;
    repeat (8) @(negedge clk);
    mem_ready_en = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h180;
    @(negedge clk);
    redirect_pc    = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("double_redir_pc0", post_pc[0], 32'h200);
    check("double_redir_pc1", post_pc[1], 32'h204);

    // PC wrap
    redirect_to(32'hFFFF_FFFC);
    repeat (12) @(negedge clk);
    check("wrap_pc0", post_pc[0], 32'hFFFF_FFFC);
    check("wrap_p4_0", post_p4[0], 32'h0);
    check("wrap_pc1", post_pc[1], 32'h0);
    check("wrap_p4_1", post_p4[1], 32'h4);

    // reset in the middle of operation with a loaded buffer
    @(negedge clk);
    dec_ready = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #3;
    check("midrst_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    dec_ready = 1'b1;
    #3;
    check("postrst_dec_valid", {31'b0, dec_valid}, 32'd0);
    check("postrst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("postrst_req_addr", imem_req_addr, 32'h0);
    repeat (10) @(negedge clk);
    check("postrst_pc0", post_pc[0], 32'h0);

    // drain everything that was accepted
    @(negedge clk);
    mem_ready_en = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("final_state", 32'(dut.state_q), 32'(FETCH));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
